// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding,
// default widths and the encoding of the last-grant flag.
package mem_arb_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;
    localparam int WAIT_W      = 4;

    // Requester index used for request/grant vectors and the last-grant flag.
    localparam int  IDX_IF  = 0;
    localparam int  IDX_LS  = 1;
    localparam logic LAST_IF = 1'b0;
    localparam logic LAST_LS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC_IF = 2'd1,
        ST_ACC_LS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_err;

    logic              ls_req;
    logic              ls_rw;
    logic [DATA_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_done;
    logic              ls_err;

    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr, ls_req, ls_rw, ls_addr, ls_wdata,
               mem_rdata, mem_ready,
        output if_rdata, if_done, if_err, ls_rdata, ls_done, ls_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_rw, ls_addr, ls_wdata,
               mem_rdata, mem_ready,
        input  if_rdata, if_done, if_err, ls_rdata, ls_done, ls_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker. On contention the requester that was
// not granted last wins; a single requester always wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,   // 1 = load/store was granted last
    output logic [1:0] gnt_o
);

    // Pick one requester from the eligible set.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single memory port between instruction fetch and load/store.
// Each access is latched at grant, runs until mem_ready or a wait timeout,
// and ends with a one-cycle done pulse to the owning requester.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

    arb_state_e        state_q;
    logic              last_q;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;

    logic              if_done_q, if_err_q, ls_done_q, ls_err_q;
    logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
    logic              mem_en_q, mem_we_q;
    logic [DATA_W-1:0] mem_addr_q, mem_wdata_q;

    logic [1:0]        elig_s;
    logic [1:0]        gnt_s;

    // A requester still seeing its done pulse is holding a stale request.
    assign elig_s[IDX_IF] = bus.if_req & ~if_done_q;
    assign elig_s[IDX_LS] = bus.ls_req & ~ls_done_q;
    assign wait_d         = wait_q + 4'd1;

    rr_arb2 u_rr (
        .req_i  (elig_s),
        .last_i (last_q),
        .gnt_o  (gnt_s)
    );

    // Arbitration FSM with all requester and memory outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_q      <= LAST_LS;
            wait_q      <= 4'd0;
            if_done_q   <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_done_q   <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // Completion outputs are pulses; they only rise on the end edge.
            if_done_q  <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= '0;
            ls_done_q  <= 1'b0;
            ls_err_q   <= 1'b0;
            ls_rdata_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    wait_q <= 4'd0;
                    if (gnt_s[IDX_IF]) begin
                        state_q     <= ST_ACC_IF;
                        last_q      <= LAST_IF;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                    end else if (gnt_s[IDX_LS]) begin
                        state_q     <= ST_ACC_LS;
                        last_q      <= LAST_LS;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.ls_rw;
                        mem_addr_q  <= bus.ls_addr;
                        mem_wdata_q <= bus.ls_rw ? bus.ls_wdata : '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACC_IF, ST_ACC_LS: begin
                    if (bus.mem_ready || (wait_d == TIMEOUT_C)) begin
                        // Access ends: either data arrived or the wait expired.
                        state_q     <= ST_IDLE;
                        wait_q      <= 4'd0;
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        if (state_q == ST_ACC_IF) begin
                            if_done_q  <= 1'b1;
                            if_err_q   <= ~bus.mem_ready;
                            if_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
                        end else begin
                            ls_done_q  <= 1'b1;
                            ls_err_q   <= ~bus.mem_ready;
                            // Stores return zero; mem_we_q still marks a store here.
                            ls_rdata_q <= (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
                        end
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    wait_q      <= 4'd0;
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                end
            endcase
        end
    end

    assign bus.if_done   = if_done_q;
    assign bus.if_err    = if_err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_done   = ls_done_q;
    assign bus.ls_err    = ls_err_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: load, store, contention, round-robin,
// timeout, reset during an access and a request held across its done pulse.
module tb_mem_arbiter;

    localparam int DW = 16;
    localparam int TO = 15;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if #(.DATA_W(DW)) bus ();

    mem_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven and
    // outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = 16'h0000;
        bus.ls_req    = 1'b0;
        bus.ls_rw     = 1'b0;
        bus.ls_addr   = 16'h0000;
        bus.ls_wdata  = 16'h0000;
        bus.mem_rdata = 16'h0000;
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        // ---- reset state
        check_eq("rst_mem_en",   16'(bus.mem_en),  16'd0);
        check_eq("rst_if_done",  16'(bus.if_done), 16'd0);
        check_eq("rst_ls_done",  16'(bus.ls_done), 16'd0);
        check_eq("rst_mem_addr", bus.mem_addr,     16'h0000);
        reset = 1'b1;

        // ---- contention right after reset: IF first, then LS
        bus.if_req = 1'b1; bus.if_addr = 16'h0100;
        bus.ls_req = 1'b1; bus.ls_addr = 16'h0200; bus.ls_rw = 1'b0;
        tick();                                      // cycle 1
        check_eq("cont_en1",   16'(bus.mem_en), 16'd1);
        check_eq("cont_addr1", bus.mem_addr,    16'h0100);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'hAAAA;
        tick();                                      // cycle 2
        check_eq("cont_if_done",  16'(bus.if_done), 16'd1);
        check_eq("cont_if_rdata", bus.if_rdata,     16'hAAAA);
        check_eq("cont_gap",      16'(bus.mem_en),  16'd0);
        bus.if_req = 1'b0; bus.mem_ready = 1'b0;
        tick();                                      // cycle 3
        check_eq("cont_en3",   16'(bus.mem_en), 16'd1);
        check_eq("cont_addr3", bus.mem_addr,    16'h0200);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h5555;
        tick();                                      // cycle 4
        check_eq("cont_ls_done",  16'(bus.ls_done), 16'd1);
        check_eq("cont_ls_rdata", bus.ls_rdata,     16'h5555);
        idle_inputs();
        tick();

        // ---- IF alone, then contention: LS must win now
        bus.if_req = 1'b1; bus.if_addr = 16'h0300;
        tick();
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h0001;
        tick();
        check_eq("rr_if_done", 16'(bus.if_done), 16'd1);
        bus.mem_ready = 1'b0;
        bus.ls_req = 1'b1; bus.ls_addr = 16'h0400;   // IF still requesting
        tick();
        check_eq("rr_ls_first", bus.mem_addr, 16'h0400);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h0002;
        tick();
        check_eq("rr_ls_done", 16'(bus.ls_done), 16'd1);
        idle_inputs();
        tick();
        tick();

        // ---- single load
        bus.ls_req = 1'b1; bus.ls_rw = 1'b0; bus.ls_addr = 16'h0010;
        tick();                                      // cycle 1
        check_eq("ld_en",   16'(bus.mem_en), 16'd1);
        check_eq("ld_we",   16'(bus.mem_we), 16'd0);
        check_eq("ld_addr", bus.mem_addr,    16'h0010);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'hBEEF;
        tick();                                      // cycle 2
        check_eq("ld_done",  16'(bus.ls_done), 16'd1);
        check_eq("ld_rdata", bus.ls_rdata,     16'hBEEF);
        check_eq("ld_err",   16'(bus.ls_err),  16'd0);
        idle_inputs();
        tick();
        check_eq("ld_done_pulse", 16'(bus.ls_done), 16'd0);

        // ---- store, inputs changed after grant must be ignored
        bus.ls_req = 1'b1; bus.ls_rw = 1'b1; bus.ls_addr = 16'h0020; bus.ls_wdata = 16'h1234;
        tick();                                      // cycle 1
        check_eq("st_we1",    16'(bus.mem_we), 16'd1);
        check_eq("st_wdata1", bus.mem_wdata,   16'h1234);
        bus.ls_addr = 16'h0F0F; bus.ls_wdata = 16'h9999; bus.ls_rw = 1'b0;
        tick();                                      // cycle 2
        check_eq("st_we2",    16'(bus.mem_we), 16'd1);
        check_eq("st_addr2",  bus.mem_addr,    16'h0020);
        check_eq("st_wdata2", bus.mem_wdata,   16'h1234);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'hFFFF;
        tick();                                      // cycle 3
        check_eq("st_done",  16'(bus.ls_done), 16'd1);
        check_eq("st_rdata", bus.ls_rdata,     16'h0000);
        check_eq("st_we_off",16'(bus.mem_we),  16'd0);
        idle_inputs();
        tick();

        // ---- mem_ready in IDLE is ignored
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h7777;
        tick();
        check_eq("idle_rdy_if", 16'(bus.if_done), 16'd0);
        check_eq("idle_rdy_ls", 16'(bus.ls_done), 16'd0);
        idle_inputs();

        // ---- timeout on fetch; requester drops req mid-access
        bus.if_req = 1'b1; bus.if_addr = 16'h0040; bus.mem_rdata = 16'hDEAD;
        for (int c = 1; c <= TO; c++) begin
            tick();
            if (c == 3) bus.if_req = 1'b0;
            check_eq("to_en_wait",   16'(bus.mem_en),  16'd1);
            check_eq("to_done_wait", 16'(bus.if_done), 16'd0);
        end
        tick();                                      // cycle TO+1
        check_eq("to_done",  16'(bus.if_done), 16'd1);
        check_eq("to_err",   16'(bus.if_err),  16'd1);
        check_eq("to_rdata", bus.if_rdata,     16'h0000);
        check_eq("to_en",    16'(bus.mem_en),  16'd0);
        idle_inputs();
        tick();
        check_eq("to_en_after", 16'(bus.mem_en), 16'd0);

        // ---- reset in the middle of a load/store access
        bus.ls_req = 1'b1; bus.ls_rw = 1'b1; bus.ls_addr = 16'h0050; bus.ls_wdata = 16'hCAFE;
        tick();
        check_eq("mr_en", 16'(bus.mem_en), 16'd1);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h4321;
        reset = 1'b0;
        #1;
        check_eq("mr_en_async",   16'(bus.mem_en),  16'd0);
        check_eq("mr_we_async",   16'(bus.mem_we),  16'd0);
        check_eq("mr_addr_async", bus.mem_addr,     16'h0000);
        tick();
        check_eq("mr_no_done", 16'(bus.ls_done), 16'd0);
        bus.mem_ready = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 16'h0060;
        reset = 1'b1;
        tick();
        check_eq("mr_if_first", bus.mem_addr, 16'h0060);
        bus.mem_ready = 1'b1;
        tick();
        check_eq("mr_if_done", 16'(bus.if_done), 16'd1);
        idle_inputs();
        tick();

        // ---- request held across its done pulse: no re-grant
        bus.ls_req = 1'b1; bus.ls_rw = 1'b0; bus.ls_addr = 16'h0070;
        tick();
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h0A0A;
        tick();                                      // done cycle, req still high
        check_eq("hold_done", 16'(bus.ls_done), 16'd1);
        bus.mem_ready = 1'b0;
        tick();
        check_eq("hold_no_regrant", 16'(bus.mem_en), 16'd0);
        bus.ls_req = 1'b0;
        tick();
        check_eq("hold_idle", 16'(bus.mem_en), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, data and address width of all buses.
REQ-002 Parameter: TIMEOUT, 15, max cycles waited for mem_ready before abort (1..15).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock, all state updates on rising edge.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 if_req  in  1  instruction-fetch request, held until if_done.
REQ-007 if_addr  in  DATA_W  fetch address.
REQ-008 if_rdata  out  DATA_W  fetched word, valid while if_done=1.
REQ-009 if_done  out  1  one-cycle fetch completion pulse.
REQ-010 if_err  out  1  fetch timed out, valid with if_done.
REQ-011 ls_req  in  1  load/store request, held until ls_done.
REQ-012 ls_rw  in  1  1=store, 0=load (same sense as control-unit rw_mem).
REQ-013 ls_addr  in  DATA_W  load/store address.
REQ-014 ls_wdata  in  DATA_W  store data.
REQ-015 ls_rdata  out  DATA_W  loaded word, valid while ls_done=1; 0 for stores.
REQ-016 ls_done  out  1  one-cycle load/store completion pulse.
REQ-017 ls_err  out  1  load/store timed out, valid with ls_done.
REQ-018 mem_en  out  1  memory access strobe.
REQ-019 mem_we  out  1  memory write enable.
REQ-020 mem_addr  out  DATA_W  memory address.
REQ-021 mem_wdata  out  DATA_W  memory write data.
REQ-022 mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1.
REQ-023 mem_ready  in  1  memory completes current access this cycle.

Function
REQ-024 FSM states IDLE, ACC_IF, ACC_LS; all outputs registered.
REQ-025 IDLE: if exactly one eligible request, go to its ACC state at that edge; if both, grant the requester not granted last (round-robin).
REQ-026 A requester whose done is high this cycle is not eligible (prevents re-grant of a held req).
REQ-027 On grant, latch address/rw/wdata; mem_en=1, mem_we=(ACC_LS & ls_rw) from the next cycle until access ends.
REQ-028 mem_addr/mem_wdata stay constant throughout an access; requester input changes after grant are ignored.
REQ-029 mem_ready=1 sampled in ACC: latch mem_rdata into requester rdata, pulse done one cycle, err=0, mem_en=0, return to IDLE.
REQ-030 Minimum latency: req at cycle 0, mem_en cycle 1, mem_ready cycle 1 -> done cycle 2; next grant no earlier than cycle 2 edge -> mem_en cycle 3.
REQ-031 4-bit wait counter cleared at grant, increments each ACC cycle without mem_ready; reaching TIMEOUT aborts: mem_en=0, done=1, err=1, rdata=0, IDLE.
REQ-032 mem_ready in IDLE is ignored; req dropped mid-access is ignored (access completes).
REQ-033 Last-grant flag updates only at grant.

Reset
REQ-034 reset=0 immediately forces IDLE, all outputs 0, wait counter 0, last-grant=LS (IF wins first contention), including mid-access.
REQ-035 After reset release, first grant is evaluated at the first rising edge with reset=1.

Structure
REQ-036 Package mem_arb_pkg holds state encoding, DATA_W and TIMEOUT defaults.
REQ-037 One sub-module rr_arb2: two-requester round-robin picker (req[1:0], last, gnt[1:0]), combinational.

Verification
REQ-038 Single load: ls_req, ls_rw=0, ls_addr=0x0010, mem_ready at cycle 1 with 0xBEEF -> ls_done cycle 2, ls_rdata=0xBEEF, ls_err=0.
REQ-039 Contention: if_req and ls_req both at cycle 0 after reset -> IF granted first, LS granted next, mem_en gap of exactly one cycle.
REQ-040 Store: ls_rw=1, ls_addr=0x0020, ls_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 until mem_ready, ls_rdata=0.
REQ-041 Timeout: if_req, mem_ready held 0 -> if_done and if_err at grant+TIMEOUT cycles, if_rdata=0, mem_en low after.
REQ-042 Reset mid-access: reset=0 during ACC_LS -> all outputs 0 immediately, no ls_done; post-reset contention grants IF first.
REQ-043 Held req: ls_req kept high across ls_done -> exactly one access per request, no re-grant in done cycle.
